alu_div_seq: RTL and testbench

- Multi-cycle signed integer divider; the inverse of the ALU's single-cycle multiply (op 6'h16).
- The CPU issues a divide (op 6'h17, OP_DIV) with a start pulse and stalls on busy.
- Quotient, remainder and N/Z/V flags return on a one-cycle done pulse.
- Restoring algorithm, one quotient bit per clock, sign correction at the end.

---
 rtl/alu_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/alu_div_seq.sv | 151 +++++++++++++++
 tb/tb_alu_div_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Shared ALU op-codes, divider state encoding and 32-bit range constants.
package alu_pkg;

    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h16;
    localparam logic [5:0] OP_DIV = 6'h17;

    localparam int ALU_WIDTH = 32;
    localparam logic [ALU_WIDTH-1:0] ALU_MIN = 32'h8000_0000;
    localparam logic [ALU_WIDTH-1:0] ALU_MAX = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // A kept remainder is below the divisor, so only the shifted value needs the extra bit.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - Sequential signed restoring divider (OP_DIV); DIV_EARLY_OUT_EN enables small-dividend fast path.
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ALU_in1,
    input  logic [WIDTH-1:0] ALU_in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             N,
    output logic             Z,
    output logic             V
);

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] div_abs;
    logic             q_neg;
    logic             r_neg;
    logic             fast;
    logic             v_pend;

    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic             div_zero;
    logic             min_ovf;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    always_comb begin
        abs1     = ALU_in1[WIDTH-1] ? (~ALU_in1 + 1'b1) : ALU_in1;
        abs2     = ALU_in2[WIDTH-1] ? (~ALU_in2 + 1'b1) : ALU_in2;
        div_zero = (ALU_in2 == '0);
        min_ovf  = (ALU_in1 == MIN_VAL) && (ALU_in2 == ALL_ONES);
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_acc),
        .dvd_bit(dvd_sh[WIDTH-1]),
        .divisor(div_abs),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    // Fast-path results are preloaded raw at start and bypass sign correction.
    always_comb begin
        q_fin = dvd_sh;
        r_fin = rem_acc;
        if (!fast) begin
            if (q_neg) q_fin = ~dvd_sh + 1'b1;
            if (r_neg) r_fin = ~rem_acc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_acc   <= '0;
            dvd_sh    <= '0;
            div_abs   <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            fast      <= 1'b0;
            v_pend    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            N         <= 1'b0;
            Z         <= 1'b1;
            V         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        cnt     <= '0;
                        q_neg   <= ALU_in1[WIDTH-1] ^ ALU_in2[WIDTH-1];
                        r_neg   <= ALU_in1[WIDTH-1];
                        div_abs <= abs2;
                        if (div_zero) begin
                            fast    <= 1'b1;
                            v_pend  <= 1'b1;
                            dvd_sh  <= ALL_ONES;
                            rem_acc <= ALU_in1;
                            state   <= FIX;
                        end else if (min_ovf) begin
                            fast    <= 1'b1;
                            v_pend  <= 1'b1;
                            dvd_sh  <= MIN_VAL;
                            rem_acc <= '0;
                            state   <= FIX;
`ifdef DIV_EARLY_OUT_EN
                        end else if (abs1 < abs2) begin
                            fast    <= 1'b1;
                            v_pend  <= 1'b0;
                            dvd_sh  <= '0;
                            rem_acc <= ALU_in1;
                            state   <= FIX;
`endif
                        end else begin
                            fast    <= 1'b0;
                            v_pend  <= 1'b0;
                            dvd_sh  <= abs1;
                            rem_acc <= '0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    // dvd_sh shifts dividend bits out the top and quotient bits in the bottom.
                    rem_acc <= step_rem;
                    dvd_sh  <= {dvd_sh[WIDTH-2:0], step_q};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) state <= FIX;
                end
                FIX: begin
                    quotient  <= q_fin;
                    remainder <= r_fin;
                    N         <= q_fin[WIDTH-1];
                    Z         <= (q_fin == '0);
                    V         <= v_pend;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - Directed self-checking bench for alu_div_seq.
module tb_alu_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] ALU_in1;
    logic [31:0] ALU_in2;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        N;
    logic        Z;
    logic        V;

    int passed = 0;
    int total  = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = 33;
`endif

    alu_div_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ALU_in1  (ALU_in1),
        .ALU_in2  (ALU_in2),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .N        (N),
        .Z        (Z),
        .V        (V)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Returns just after edge E0 with start already dropped.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALU_in1 = a;
        ALU_in2 = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen; busy_ok drops if busy is low before done.
    task automatic wait_done(output int n, output logic busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    int   lat;
    logic bok;
    logic saw_done;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        ALU_in1 = '0;
        ALU_in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_quotient", quotient, 32'h0);
        chk("rst_remainder", remainder, 32'h0);
        chk("rst_flags_nzv", {29'd0, N, Z, V}, 32'b010);
        chk("rst_busy_done", {30'd0, busy, done}, 32'b00);

        issue(32'd13284, 32'd81);
        chk("basic_busy_e0", {31'd0, busy}, 32'd1);
        wait_done(lat, bok);
        chk("basic_latency", lat, 32'd33);
        chk("basic_busy_calc", {31'd0, bok}, 32'd1);
        chk("basic_busy_at_done", {31'd0, busy}, 32'd0);
        chk("basic_quotient", quotient, 32'd164);
        chk("basic_remainder", remainder, 32'd0);
        chk("basic_flags_nzv", {29'd0, N, Z, V}, 32'b000);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("hold_quotient", quotient, 32'd164);

        issue(-32'sd7, 32'd2);
        wait_done(lat, bok);
        chk("neg_dvd_quotient", quotient, 32'hFFFF_FFFD);
        chk("neg_dvd_remainder", remainder, 32'hFFFF_FFFF);
        chk("neg_dvd_flags_nzv", {29'd0, N, Z, V}, 32'b100);

        issue(32'd7, -32'sd2);
        wait_done(lat, bok);
        chk("neg_dvs_quotient", quotient, 32'hFFFF_FFFD);
        chk("neg_dvs_remainder", remainder, 32'd1);

        issue(32'd5, 32'd0);
        wait_done(lat, bok);
        chk("dz_latency", lat, 32'd1);
        chk("dz_quotient", quotient, 32'hFFFF_FFFF);
        chk("dz_remainder", remainder, 32'd5);
        chk("dz_flags_nzv", {29'd0, N, Z, V}, 32'b101);

        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bok);
        chk("ovf_latency", lat, 32'd1);
        chk("ovf_quotient", quotient, 32'h8000_0000);
        chk("ovf_remainder", remainder, 32'd0);
        chk("ovf_flags_nzv", {29'd0, N, Z, V}, 32'b101);

        issue(32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy_done", {30'd0, busy, done}, 32'b00);
        chk("abort_quotient", quotient, 32'h0);
        chk("abort_remainder", remainder, 32'h0);
        chk("abort_flags_nzv", {29'd0, N, Z, V}, 32'b010);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);

        issue(32'd100, 32'd7);
        wait_done(lat, bok);
        chk("after_abort_quotient", quotient, 32'd14);
        chk("after_abort_remainder", remainder, 32'd2);

        issue(32'd13284, 32'd81);
        repeat (4) @(posedge clk);
        @(negedge clk);
        ALU_in1 = 32'd9;
        ALU_in2 = 32'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bok);
        chk("ignored_start_latency", lat + 5, 32'd33);
        chk("ignored_start_quotient", quotient, 32'd164);
        chk("ignored_start_remainder", remainder, 32'd0);

        issue(32'd3, 32'd10);
        chk("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bok);
        chk("small_latency", lat, SMALL_LAT);
        chk("small_quotient", quotient, 32'd0);
        chk("small_remainder", remainder, 32'd3);
        chk("small_flags_nzv", {29'd0, N, Z, V}, 32'b010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
